// File: rtl/spi_slave_reg_ctrl.sv
// Frame controller between the SPI slave core and the register bus: the first word of a
// chip-select frame is a command, following words become register writes or paced reads.
module spi_slave_reg_ctrl #(
    parameter int                    DATA_WIDTH  = 16,
    parameter int                    ADDR_WIDTH  = 8,
    parameter int                    ACK_TIMEOUT = 64,
    parameter logic [DATA_WIDTH-1:0] ERR_PATTERN = 16'hDEAD
) (
    input  logic                  i_sys_clk,
    input  logic                  i_sys_rst_n,
    input  logic                  i_spi_active,
    input  logic [DATA_WIDTH-1:0] i_rx_data,
    input  logic                  i_rx_valid,
    output logic [DATA_WIDTH-1:0] o_tx_data,
    output logic                  o_tx_load,
    output logic [ADDR_WIDTH-1:0] o_reg_addr,
    output logic [DATA_WIDTH-1:0] o_reg_wdata,
    output logic                  o_reg_we,
    output logic                  o_reg_re,
    input  logic [DATA_WIDTH-1:0] i_reg_rdata,
    input  logic                  i_reg_ack,
    output logic                  o_busy,
    output logic                  o_err_timeout,
    output logic                  o_err_overrun,
    output logic                  o_frame_done
);
    localparam int TW = $clog2(ACK_TIMEOUT + 1);

    typedef enum logic [2:0] {
        IDLE, CMD, WR_DATA, WR_ACK, RD_ACK, RD_WAIT, DRAIN, FLUSH
    } state_t;

    state_t                  state, nxt;
    logic                    act_q;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic [7:0]              cnt_q;
    logic [DATA_WIDTH-1:0]   hold_q;
    logic                    hold_full;
    logic                    cmd_seen;
    logic [TW-1:0]           tmo_cnt;

    logic cs_rise, cs_fall, rxv, req, ack_hit, tmo_hit;
    logic lat_cmd, wr_issue, rd_issue, hold_put, ovr;

    // State register
    always_ff @(posedge i_sys_clk or negedge i_sys_rst_n) begin
        if (!i_sys_rst_n) state <= IDLE;
        else              state <= nxt;
    end

    // Next-state logic; frame end overrides everything except an access still in flight
    always_comb begin
        nxt = state;
        if (state == FLUSH) begin
            if (ack_hit || tmo_hit || !req) nxt = IDLE;
        end else if (state != IDLE && cs_fall) begin
            nxt = (req && !ack_hit && !tmo_hit) ? FLUSH : IDLE;
        end else begin
            case (state)
                IDLE:    if (cs_rise) nxt = CMD;
                CMD:     if (rxv) nxt = i_rx_data[15] ? RD_ACK : WR_DATA;
                WR_DATA: if (wr_issue) nxt = WR_ACK;
                WR_ACK: begin
                    if (ack_hit)      nxt = (cnt_q == 8'd1) ? DRAIN : WR_DATA;
                    else if (tmo_hit) nxt = DRAIN;
                end
                RD_ACK: begin
                    if (ack_hit)      nxt = RD_WAIT;
                    else if (tmo_hit) nxt = DRAIN;
                end
                RD_WAIT: if (rxv) nxt = (cnt_q != 8'd0) ? RD_ACK : DRAIN;
                default: nxt = state;
            endcase
        end
    end

    // Output / control decode
    always_comb begin
        cs_rise  = i_spi_active & ~act_q;
        cs_fall  = ~i_spi_active & act_q;
        rxv      = i_rx_valid & i_spi_active;
        req      = o_reg_we | o_reg_re;
        ack_hit  = req & i_reg_ack;
        tmo_hit  = req & ~i_reg_ack & (tmo_cnt == TW'(ACK_TIMEOUT - 1));
        lat_cmd  = (state == CMD) & rxv;
        wr_issue = (state == WR_DATA) & (rxv | hold_full) & ~cs_fall;
        rd_issue = (lat_cmd & i_rx_data[15]) |
                   ((state == RD_WAIT) & rxv & (cnt_q != 8'd0));
        // A word arriving while the hold slot is being drained refills it
        hold_put = rxv & (((state == WR_ACK) & ~hold_full) |
                          ((state == WR_DATA) & hold_full));
        ovr      = rxv & (((state == WR_ACK) & hold_full) | (state == DRAIN));
        o_busy   = (state != IDLE);
    end

    // Datapath and registered outputs
    always_ff @(posedge i_sys_clk or negedge i_sys_rst_n) begin
        if (!i_sys_rst_n) begin
            act_q         <= 1'b0;
            addr_q        <= '0;
            cnt_q         <= '0;
            hold_q        <= '0;
            hold_full     <= 1'b0;
            cmd_seen      <= 1'b0;
            tmo_cnt       <= '0;
            o_tx_data     <= '0;
            o_tx_load     <= 1'b0;
            o_reg_addr    <= '0;
            o_reg_wdata   <= '0;
            o_reg_we      <= 1'b0;
            o_reg_re      <= 1'b0;
            o_err_timeout <= 1'b0;
            o_err_overrun <= 1'b0;
            o_frame_done  <= 1'b0;
        end else begin
            act_q        <= i_spi_active;
            o_tx_load    <= 1'b0;
            o_frame_done <= (state != IDLE) && (nxt == IDLE) && cmd_seen;

            if (state == IDLE && cs_rise) begin
                o_err_timeout <= 1'b0;
                o_err_overrun <= 1'b0;
                cmd_seen      <= 1'b0;
            end

            if (lat_cmd) begin
                addr_q   <= i_rx_data[ADDR_WIDTH-1:0];
                cnt_q    <= {1'b0, i_rx_data[14:8]} + 8'd1;
                cmd_seen <= 1'b1;
            end

            if (ack_hit || tmo_hit) begin
                o_reg_we <= 1'b0;
                o_reg_re <= 1'b0;
            end
            if (tmo_hit) o_err_timeout <= 1'b1;
            if (ovr)     o_err_overrun <= 1'b1;

            if (ack_hit && (state == WR_ACK || state == RD_ACK)) begin
                addr_q <= addr_q + ADDR_WIDTH'(1);
                cnt_q  <= cnt_q - 8'd1;
            end

            // The master is still clocking, so a failed read still hands it a marker word
            if (state == RD_ACK && !cs_fall) begin
                if (ack_hit) begin
                    o_tx_data <= i_reg_rdata;
                    o_tx_load <= 1'b1;
                end else if (tmo_hit) begin
                    o_tx_data <= ERR_PATTERN;
                    o_tx_load <= 1'b1;
                end
            end

            if (wr_issue) begin
                o_reg_we    <= 1'b1;
                o_reg_addr  <= addr_q;
                o_reg_wdata <= hold_full ? hold_q : i_rx_data;
            end
            if (rd_issue) begin
                o_reg_re   <= 1'b1;
                o_reg_addr <= lat_cmd ? i_rx_data[ADDR_WIDTH-1:0] : addr_q;
            end

            if (wr_issue || rd_issue) tmo_cnt <= '0;
            else if (req)             tmo_cnt <= tmo_cnt + TW'(1);

            if (nxt != WR_DATA && nxt != WR_ACK) begin
                hold_full <= 1'b0;
            end else if (hold_put) begin
                hold_q    <= i_rx_data;
                hold_full <= 1'b1;
            end else if (wr_issue) begin
                hold_full <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_spi_slave_reg_ctrl.sv
// Randomized frame-level bench for spi_slave_reg_ctrl: a register-file responder plus
// a transaction model predicting writes, reads, tx loads and flags per frame.
module tb_spi_slave_reg_ctrl;
    localparam int DW = 16;
    localparam int AW = 8;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic          spi_active = 1'b0;
    logic [DW-1:0] rx_data = '0;
    logic          rx_valid = 1'b0;
    logic [DW-1:0] tx_data;
    logic          tx_load;
    logic [AW-1:0] reg_addr;
    logic [DW-1:0] reg_wdata;
    logic          reg_we, reg_re;
    logic [DW-1:0] reg_rdata;
    logic          reg_ack;
    logic          busy, err_tmo, err_ovr, frame_done;

    int n_cmp = 0;
    int n_err = 0;

    logic [DW-1:0] mem [256];
    int            ack_dly = 2;
    bit            ack_en = 1'b1;
    int            rsp_wt;

    logic [AW-1:0] obs_wa[$];
    logic [DW-1:0] obs_wd[$];
    logic [AW-1:0] obs_ra[$];
    logic [DW-1:0] obs_tx[$];
    int            fd_cnt = 0;
    int            re_cyc = 0;
    int            we_cyc = 0;
    logic [DW-1:0] words[$];

    spi_slave_reg_ctrl dut (
        .i_sys_clk    (clk),
        .i_sys_rst_n  (rst_n),
        .i_spi_active (spi_active),
        .i_rx_data    (rx_data),
        .i_rx_valid   (rx_valid),
        .o_tx_data    (tx_data),
        .o_tx_load    (tx_load),
        .o_reg_addr   (reg_addr),
        .o_reg_wdata  (reg_wdata),
        .o_reg_we     (reg_we),
        .o_reg_re     (reg_re),
        .i_reg_rdata  (reg_rdata),
        .i_reg_ack    (reg_ack),
        .o_busy       (busy),
        .o_err_timeout(err_tmo),
        .o_err_overrun(err_ovr),
        .o_frame_done (frame_done)
    );

    always #5 clk = ~clk;

    // Register file responder: acks a held request after ack_dly cycles
    initial begin
        reg_ack   = 1'b0;
        reg_rdata = '0;
        rsp_wt    = 0;
        for (int i = 0; i < 256; i++) mem[i] = 16'($urandom);
        mem[8'hFE] = 16'hA5A5;
        mem[8'hFF] = 16'h5A5A;
        forever begin
            @(posedge clk); #1;
            if (reg_ack) begin
                reg_ack = 1'b0;
                rsp_wt  = 0;
            end else if ((reg_we || reg_re) && rst_n) begin
                rsp_wt++;
                if (ack_en && rsp_wt >= ack_dly) begin
                    reg_ack = 1'b1;
                    rsp_wt  = 0;
                    if (reg_we) mem[reg_addr] = reg_wdata;
                    reg_rdata = mem[reg_addr];
                end
            end else begin
                rsp_wt = 0;
            end
        end
    end

    always @(negedge clk) begin
        if (reg_we && reg_ack) begin
            obs_wa.push_back(reg_addr);
            obs_wd.push_back(reg_wdata);
        end
        if (reg_re && reg_ack) obs_ra.push_back(reg_addr);
        if (tx_load)    obs_tx.push_back(tx_data);
        if (frame_done) fd_cnt++;
        if (reg_re)     re_cyc++;
        if (reg_we)     we_cyc++;
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic send(input logic [DW-1:0] w);
        rx_data  = w;
        rx_valid = 1'b1;
        tick(1);
        rx_valid = 1'b0;
    endtask

    task automatic cs(input logic v);
        spi_active = v;
        tick(1);
    endtask

    task automatic wait_idle(input string tag);
        int n = 0;
        while (busy && n < 300) begin
            tick(1);
            n++;
        end
        chk({tag, " idle"}, 32'(busy), 32'd0);
    endtask

    // One command frame; expectations follow from the command and the word count alone
    task automatic run_frame(input bit rd, input logic [7:0] a, input int len,
                             input int dly, input int gap, input string tag);
        int bw, br, bt, bf, nw, nx;
        logic [15:0] cmd;
        logic [7:0]  ea;
        bw = obs_wa.size(); br = obs_ra.size(); bt = obs_tx.size(); bf = fd_cnt;
        ack_en  = 1'b1;
        ack_dly = dly;
        cmd = {rd, 7'(len - 1), a};
        cs(1'b1); tick(2); send(cmd);
        foreach (words[i]) begin
            tick(gap);
            send(words[i]);
        end
        tick(gap); cs(1'b0); wait_idle(tag); tick(2);
        nw = words.size();
        if (!rd) begin
            nx = (nw < len) ? nw : len;
            chk({tag, " wr_n"}, 32'(obs_wa.size() - bw), 32'(nx));
            chk({tag, " rd_n"}, 32'(obs_ra.size() - br), 32'd0);
            for (int i = 0; i < nx; i++) begin
                if (bw + i < obs_wa.size()) begin
                    ea = a + 8'(i);
                    chk({tag, " wa"}, 32'(obs_wa[bw+i]), 32'(ea));
                    chk({tag, " wd"}, 32'(obs_wd[bw+i]), 32'(words[i]));
                end
            end
        end else begin
            nx = (nw + 1 < len) ? nw + 1 : len;
            chk({tag, " rd_n"}, 32'(obs_ra.size() - br), 32'(nx));
            chk({tag, " tx_n"}, 32'(obs_tx.size() - bt), 32'(nx));
            chk({tag, " wr_n"}, 32'(obs_wa.size() - bw), 32'd0);
            for (int i = 0; i < nx; i++) begin
                ea = a + 8'(i);
                if (br + i < obs_ra.size()) chk({tag, " ra"}, 32'(obs_ra[br+i]), 32'(ea));
                if (bt + i < obs_tx.size()) chk({tag, " tx"}, 32'(obs_tx[bt+i]), 32'(mem[ea]));
            end
        end
        chk({tag, " ovr"}, 32'(err_ovr), 32'(nw > len));
        chk({tag, " tmo"}, 32'(err_tmo), 32'd0);
        chk({tag, " fd"},  32'(fd_cnt - bf), 32'd1);
    endtask

    initial begin
        int b0, b1, b2, len, nw;
        bit rd;

        // Reset state
        tick(3);
        chk("rst busy", 32'(busy), 0);
        chk("rst we", 32'(reg_we), 0);
        chk("rst re", 32'(reg_re), 0);
        rst_n = 1'b1;
        tick(2);
        chk("rst tx", 32'(tx_data), 0);
        chk("rst txl", 32'(tx_load), 0);
        chk("rst addr", 32'(reg_addr), 0);
        chk("rst wdata", 32'(reg_wdata), 0);
        chk("rst tmo", 32'(err_tmo), 0);
        chk("rst ovr", 32'(err_ovr), 0);
        chk("rst fd", 32'(frame_done), 0);

        // Words outside chip select do nothing
        b0 = re_cyc; b1 = we_cyc;
        send(16'h8012); send(16'h0012); tick(3);
        chk("cs_low busy", 32'(busy), 0);
        chk("cs_low bus", 32'(re_cyc - b0 + we_cyc - b1), 0);

        words = '{16'h1111, 16'h2222, 16'h3333};
        run_frame(1'b0, 8'h10, 3, 2, 12, "wr_burst");

        b0 = obs_tx.size();
        words = '{16'h0000, 16'h0000};
        run_frame(1'b1, 8'hFE, 2, 2, 12, "rd_burst");
        chk("rd_burst tx0", 32'(obs_tx[b0]), 32'h0000A5A5);
        chk("rd_burst tx1", 32'(obs_tx[b0+1]), 32'h00005A5A);

        words = '{16'h0001, 16'h0002};
        run_frame(1'b1, 8'hFF, 3, 1, 12, "wrap");

        // Read timeout
        b0 = re_cyc; b1 = obs_tx.size(); b2 = fd_cnt;
        ack_en = 1'b0;
        cs(1'b1); tick(2); send(16'h8040); tick(80);
        chk("tmo re_cycles", 32'(re_cyc - b0), 32'd64);
        chk("tmo tx_n", 32'(obs_tx.size() - b1), 32'd1);
        if (obs_tx.size() > b1) chk("tmo tx", 32'(obs_tx[b1]), 32'h0000DEAD);
        chk("tmo flag", 32'(err_tmo), 1);
        chk("tmo busy", 32'(busy), 1);
        cs(1'b0); wait_idle("tmo"); tick(2);
        chk("tmo sticky", 32'(err_tmo), 1);
        chk("tmo fd", 32'(fd_cnt - b2), 1);
        b2 = fd_cnt;
        cs(1'b1); tick(3);
        chk("tmo clear", 32'(err_tmo), 0);
        cs(1'b0); wait_idle("empty"); tick(2);
        chk("empty fd", 32'(fd_cnt - b2), 0);
        ack_en = 1'b1;

        // Overrun: write of length 1 with three words while the ack is held off
        b0 = obs_wa.size();
        ack_en = 1'b0;
        cs(1'b1); tick(2); send(16'h0030);
        tick(2); send(16'hAAA1); tick(2); send(16'hBBB2); tick(2); send(16'hCCC3);
        tick(4); ack_dly = 1; ack_en = 1'b1; tick(10);
        send(16'hDDD4); tick(3);
        chk("ovr wr_n", 32'(obs_wa.size() - b0), 1);
        if (obs_wa.size() > b0) begin
            chk("ovr wa", 32'(obs_wa[b0]), 32'h30);
            chk("ovr wd", 32'(obs_wd[b0]), 32'hAAA1);
        end
        chk("ovr flag", 32'(err_ovr), 1);
        chk("ovr tmo", 32'(err_tmo), 0);
        cs(1'b0); wait_idle("ovr"); tick(2);
        chk("ovr wr_n end", 32'(obs_wa.size() - b0), 1);

        // Abort: chip select drops while a write waits for its ack
        b0 = obs_wa.size(); b2 = fd_cnt;
        ack_en = 1'b0;
        cs(1'b1); tick(2); send(16'h0050); tick(2); send(16'h7E57); tick(3);
        cs(1'b0); tick(5);
        chk("abort busy", 32'(busy), 1);
        chk("abort we", 32'(reg_we), 1);
        ack_dly = 1; ack_en = 1'b1;
        wait_idle("abort"); tick(2);
        chk("abort wr_n", 32'(obs_wa.size() - b0), 1);
        if (obs_wa.size() > b0) chk("abort wd", 32'(obs_wd[b0]), 32'h7E57);
        chk("abort we_off", 32'(reg_we), 0);
        chk("abort fd", 32'(fd_cnt - b2), 1);

        // Maximum length with address wrap
        words.delete();
        for (int i = 0; i < 128; i++) words.push_back(16'($urandom));
        run_frame(1'b0, 8'hC0, 128, 2, 6, "len128");

        // Random frames
        for (int t = 0; t < 20; t++) begin
            rd  = 1'($urandom_range(0, 1));
            len = $urandom_range(1, 6);
            nw  = len - 1 + $urandom_range(0, 2);
            words.delete();
            for (int i = 0; i < nw; i++) words.push_back(16'($urandom));
            run_frame(rd, 8'($urandom), len, $urandom_range(1, 4), 12, "rand");
        end

        // Reset in the middle of an access
        ack_en = 1'b0;
        cs(1'b1); tick(2); send(16'h0060); tick(1); send(16'h1234); tick(2);
        chk("rst_mid we", 32'(reg_we), 1);
        rst_n = 1'b0; #1;
        chk("rst_mid we_drop", 32'(reg_we), 0);
        chk("rst_mid busy", 32'(busy), 0);
        spi_active = 1'b0;
        tick(2); rst_n = 1'b1; tick(2);
        ack_en = 1'b1;
        chk("rst_mid idle", 32'(busy), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish, compared %0d", n_cmp);
        $fatal(1, "watchdog");
    end

endmodule
